// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared types and constants for the register-file writeback controller
package rf_wb_pkg;

    localparam int WB_AW    = 5;
    localparam int WB_DW    = 32;
    localparam int WB_DEPTH = 4;

    localparam logic [WB_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [WB_AW-1:0] rd;
        logic [WB_DW-1:0] data;
        logic             kill;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - load-result circular buffer with per-entry kill marking and full visibility
module wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  wb_entry_t                     push_entry,
    input  logic                          pop,
    input  logic [DEPTH-1:0]              kill_set,
    output wb_entry_t                     head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        count,
    output logic [WB_AW-1:0]              entry_rd [DEPTH],
    output logic [DEPTH-1:0]              entry_kill,
    output logic [DEPTH-1:0]              entry_valid
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t     mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic [PW-1:0] off;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_set[i]) begin
                    mem[i].kill <= 1'b1;
                end
            end
            // push never targets a live slot, so it cannot collide with a kill mark
            if (push) begin
                mem[wr_ptr[PW-1:0]] <= push_entry;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

    // a slot is live when its distance from the read pointer is below the occupancy
    always_comb begin
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off            = PW'(i) - rd_ptr[PW-1:0];
            entry_valid[i] = ({1'b0, off} < count);
            entry_rd[i]    = mem[i].rd;
            entry_kill[i]  = mem[i].kill;
        end
    end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// rtl/rf_writeback_ctrl.sv - register-file write port arbiter for ALU and buffered load results
module rf_writeback_ctrl
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [AW-1:0]              alu_rd,
    input  logic [DW-1:0]              alu_data,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [AW-1:0]              ld_rd,
    input  logic [DW-1:0]              ld_data,
    output logic                       we3,
    output logic [AW-1:0]              a3,
    output logic [DW-1:0]              wd3,
    input  logic [AW-1:0]              q_rd,
    output logic                       q_hit,
    output logic [$clog2(DEPTH+1)-1:0] pending_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic             alu_issue;
    logic             ld_push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [PW:0]      count;
    logic [DEPTH-1:0] kill_set;
    logic [DEPTH-1:0] entry_kill;
    logic [DEPTH-1:0] entry_valid;
    logic [WB_AW-1:0] entry_rd [DEPTH];
    wb_entry_t        push_entry;
    wb_entry_t        head;

    assign alu_issue = alu_valid && (alu_rd != REG_ZERO);
    assign ld_ready  = !rst && !full;
    assign ld_push   = ld_valid && ld_ready && (ld_rd != REG_ZERO);
    assign pop       = !alu_issue && !empty;

    // a load arriving alongside a younger ALU write to the same register is born dead
    assign push_entry = '{rd: ld_rd, data: ld_data, kill: alu_issue && (ld_rd == alu_rd)};

    always_comb begin
        kill_set = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill_set[i] = alu_issue && entry_valid[i] && (entry_rd[i] == alu_rd);
        end
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (ld_push),
        .push_entry  (push_entry),
        .pop         (pop),
        .kill_set    (kill_set),
        .head        (head),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .entry_rd    (entry_rd),
        .entry_kill  (entry_kill),
        .entry_valid (entry_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            we3 <= 1'b0;
            a3  <= '0;
            wd3 <= '0;
        end else if (alu_issue) begin
            we3 <= 1'b1;
            a3  <= alu_rd;
            wd3 <= alu_data;
        end else if (pop) begin
            we3 <= !head.kill;
            a3  <= head.rd;
            wd3 <= head.data;
        end else begin
            we3 <= 1'b0;
        end
    end

    always_comb begin
        q_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && !entry_kill[i] && (entry_rd[i] == q_rd)) begin
                q_hit = 1'b1;
            end
        end
        if (rst || (q_rd == REG_ZERO)) begin
            q_hit = 1'b0;
        end
    end

    assign pending_cnt = rst ? '0 : CW'(count);

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// tb/tb_rf_writeback_ctrl.sv - randomized self-checking bench for rf_writeback_ctrl
module tb_rf_writeback_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [AW-1:0] ld_rd = '0;
    logic [DW-1:0] ld_data = '0;
    logic          we3;
    logic [AW-1:0] a3;
    logic [DW-1:0] wd3;
    logic [AW-1:0] q_rd = '0;
    logic          q_hit;
    logic [CW-1:0] pending_cnt;

    always #5 clk = ~clk;

    rf_writeback_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .we3         (we3),
        .a3          (a3),
        .wd3         (wd3),
        .q_rd        (q_rd),
        .q_hit       (q_hit),
        .pending_cnt (pending_cnt)
    );

    typedef struct {
        int          rd;
        logic [31:0] data;
        bit          kill;
    } ref_t;

    ref_t        mq[$];
    int          checks = 0;
    int          failures = 0;
    int          accepts = 0;
    bit          have_exp = 0;
    bit          exp_addr_chk = 0;
    logic        exp_we = 1'b0;
    logic [31:0] exp_a3 = '0;
    logic [31:0] exp_wd3 = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one clock of stimulus; reference queue advances at the edge
    task automatic step(input bit r, input bit av, input int ard, input logic [31:0] ad,
                        input bit lv, input int lrd, input logic [31:0] ldat, input int qrd);
        bit   e_ready;
        bit   e_hit;
        bit   alu;
        int   e_cnt;
        ref_t h;
        @(negedge clk);
        if (have_exp) begin
            check_val("we3", 64'(we3), 64'(exp_we));
            if (exp_addr_chk) begin
                check_val("a3", 64'(a3), 64'(exp_a3));
                check_val("wd3", 64'(wd3), 64'(exp_wd3));
            end
        end
        rst       = r;
        alu_valid = av;
        alu_rd    = AW'(ard);
        alu_data  = ad;
        ld_valid  = lv;
        ld_rd     = AW'(lrd);
        ld_data   = ldat;
        q_rd      = AW'(qrd);
        #1;
        e_ready = !r && (mq.size() < DEPTH);
        e_cnt   = r ? 0 : mq.size();
        e_hit   = 0;
        if (!r && qrd != 0) begin
            foreach (mq[i]) if (mq[i].rd == qrd && !mq[i].kill) e_hit = 1;
        end
        check_val("ld_ready", 64'(ld_ready), 64'(e_ready));
        check_val("pending_cnt", 64'(pending_cnt), 64'(e_cnt));
        check_val("q_hit", 64'(q_hit), 64'(e_hit));
        if (lv && ld_ready) accepts++;
        @(posedge clk);
        if (r) begin
            mq.delete();
            exp_we       = 1'b0;
            exp_a3       = '0;
            exp_wd3      = '0;
            exp_addr_chk = 1;
        end else begin
            alu          = av && (ard != 0);
            exp_we       = 1'b0;
            exp_addr_chk = 0;
            if (alu) begin
                foreach (mq[i]) if (mq[i].rd == ard) mq[i].kill = 1;
                exp_we       = 1'b1;
                exp_a3       = 32'(ard);
                exp_wd3      = ad;
                exp_addr_chk = 1;
            end else if (mq.size() > 0) begin
                h = mq.pop_front();
                if (!h.kill) begin
                    exp_we       = 1'b1;
                    exp_a3       = 32'(h.rd);
                    exp_wd3      = h.data;
                    exp_addr_chk = 1;
                end
            end
            if (lv && e_ready && lrd != 0)
                mq.push_back('{rd: lrd, data: ldat, kill: (alu && lrd == ard)});
        end
        have_exp = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int acc0;
        // reset
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 32'h55, 1, 4, 32'h66, 4);
        #1;
        check_val("rst_we3", 64'(we3), 64'd0);
        check_val("rst_a3", 64'(a3), 64'd0);
        check_val("rst_wd3", 64'(wd3), 64'd0);
        idle(2);

        // single load, two-cycle latency
        step(0, 0, 0, 0, 1, 5, 32'hDEAD_BEEF, 5);
        #1 check_val("load_cnt1", 64'(pending_cnt), 64'd1);
        step(0, 0, 0, 0, 0, 0, 0, 5);
        #1;
        check_val("load_we3", 64'(we3), 64'd1);
        check_val("load_a3", 64'(a3), 64'd5);
        check_val("load_wd3", 64'(wd3), 64'hDEAD_BEEF);
        check_val("load_cnt0", 64'(pending_cnt), 64'd0);
        idle(2);

        // starvation under continuous ALU traffic
        accepts = 0;
        for (int c = 0; c < 8; c++)
            step(0, 1, c + 1, 32'h100 + 32'(c), 1, 9 + accepts, 32'h900 + 32'(accepts), 9 + c % 4);
        check_val("starve_accepts", 64'(accepts), 64'd4);
        idle(6);

        // WAW squash of a queued load
        step(0, 1, 3, 32'h33, 1, 7, 32'h11, 7);
        #1 check_val("sq_hit_before", 64'(q_hit), 64'd1);
        step(0, 1, 7, 32'h22, 0, 0, 0, 7);
        #1 check_val("sq_hit_after", 64'(q_hit), 64'd0);
        idle(3);

        // x0 destinations
        accepts = 0;
        step(0, 1, 0, 32'h77, 1, 0, 32'h88, 0);
        #1 check_val("x0_cnt", 64'(pending_cnt), 64'd0);
        check_val("x0_accept", 64'(accepts), 64'd1);
        idle(2);

        // reset with pending entries
        step(0, 1, 1, 32'h1, 1, 20, 32'h20, 21);
        step(0, 1, 1, 32'h2, 1, 21, 32'h21, 21);
        step(0, 1, 1, 32'h3, 1, 22, 32'h22, 21);
        step(1, 1, 1, 32'h4, 0, 0, 0, 21);
        #1;
        check_val("mrst_cnt", 64'(pending_cnt), 64'd0);
        check_val("mrst_we3", 64'(we3), 64'd0);
        idle(4);

        // full with concurrent pop, then wrap over 3*DEPTH transfers
        for (int c = 0; c < DEPTH; c++)
            step(0, 1, 30, 32'(c), 1, 9 + c, 32'hA0 + 32'(c), 0);
        acc0 = accepts;
        step(0, 0, 0, 0, 1, 15, 32'hF5, 15);
        check_val("full_pop_reject", 64'(accepts - acc0), 64'd0);
        step(0, 0, 0, 0, 1, 15, 32'hF5, 15);
        check_val("full_next_accept", 64'(accepts - acc0), 64'd1);
        for (int c = 0; c < 3 * DEPTH; c++)
            step(0, 0, 0, 0, 1, 1 + c % 31, 32'hB000 + 32'(c), 1 + c % 31);
        idle(DEPTH + 2);

        // randomized mix with deliberate register collisions
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, int'($urandom_range(0, 7)), $urandom,
                 int'($urandom_range(0, 7)));
        end
        idle(DEPTH + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
